// File: rtl/it8951_pkg.sv
// Shared IT8951 host-interface constants: frame preambles, command codes, responder FSM states.
package it8951_pkg;

  localparam logic [15:0] PREAMBLE_CMD   = 16'h6000;
  localparam logic [15:0] PREAMBLE_WRITE = 16'h0000;
  localparam logic [15:0] PREAMBLE_READ  = 16'h1000;

  localparam logic [15:0] CMD_SYS_RUN      = 16'h0001;
  localparam logic [15:0] CMD_STANDBY      = 16'h0002;
  localparam logic [15:0] CMD_SLEEP        = 16'h0003;
  localparam logic [15:0] CMD_REG_RD       = 16'h0010;
  localparam logic [15:0] CMD_REG_WR       = 16'h0011;
  localparam logic [15:0] CMD_LD_IMG       = 16'h0020;
  localparam logic [15:0] CMD_LD_IMG_AREA  = 16'h0021;
  localparam logic [15:0] CMD_LD_IMG_END   = 16'h0022;
  localparam logic [15:0] CMD_DPY_AREA     = 16'h0034;
  localparam logic [15:0] CMD_GET_DEV_INFO = 16'h0302;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_CMD,
    ST_WDATA,
    ST_RDUMMY,
    ST_RDATA,
    ST_DISCARD
  } state_t;

endpackage

// File: rtl/spi_slave_shifter.sv
// SPI mode-0 slave datapath: pin synchronizers, edge detect, 16-bit rx/tx shift registers.
// Edge events appear 2 clk_in cycles after a pin change; word_done fires on the internal 16th rise.
module spi_slave_shifter (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        spi_clk,
  input  logic        spi_cs,
  input  logic        spi_mosi,
  input  logic        tx_load,
  input  logic [15:0] tx_data,
  input  logic        tx_shift_en,
  output logic        word_done,
  output logic [15:0] rx_word,
  output logic        cs_rise,
  output logic        cs_fall,
  output logic        partial,
  output logic        tx_msb
);

  logic [2:0]  sclk_sync;
  logic [2:0]  cs_sync;
  logic [1:0]  mosi_sync;
  logic        armed;
  logic        skip_shift;
  logic [3:0]  bit_cnt;
  logic [15:0] rx_sr;
  logic [15:0] tx_sr;
  logic        sclk_rise;
  logic        sclk_fall;

  // armed is set only by a CS fall, so a frame interrupted by reset stays ignored until CS cycles
  assign sclk_rise = sclk_sync[1] & ~sclk_sync[2] & armed;
  assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
  assign cs_rise   = cs_sync[1] & ~cs_sync[2];
  assign cs_fall   = ~cs_sync[1] & cs_sync[2];
  assign word_done = sclk_rise && (bit_cnt == 4'd15);
  assign rx_word   = {rx_sr[14:0], mosi_sync[1]};
  assign partial   = cs_rise && armed && (bit_cnt != 4'd0) && !word_done;
  assign tx_msb    = tx_sr[15];

  always_ff @(posedge clk_in) begin
    if (rst) begin
      sclk_sync  <= '0;
      cs_sync    <= '0;
      mosi_sync  <= '0;
      armed      <= 1'b0;
      skip_shift <= 1'b0;
      bit_cnt    <= '0;
      rx_sr      <= '0;
      tx_sr      <= '0;
    end else begin
      sclk_sync <= {sclk_sync[1:0], spi_clk};
      cs_sync   <= {cs_sync[1:0], spi_cs};
      mosi_sync <= {mosi_sync[0], spi_mosi};

      if (cs_fall) begin
        armed   <= 1'b1;
        bit_cnt <= '0;
      end else if (sclk_rise) begin
        rx_sr   <= rx_word;
        bit_cnt <= bit_cnt + 4'd1;
      end
      if (cs_rise) begin
        armed   <= 1'b0;
        bit_cnt <= '0;
      end

      // the fall right after a word boundary presents the freshly loaded MSB instead of shifting
      if (tx_load)
        tx_sr <= tx_data;
      else if (sclk_fall && tx_shift_en && !skip_shift)
        tx_sr <= {tx_sr[14:0], 1'b0};

      if (word_done)
        skip_shift <= 1'b1;
      else if (sclk_fall)
        skip_shift <= 1'b0;
    end
  end

endmodule

// File: rtl/it8951_spi_responder.sv
// IT8951 host-interface responder: preamble decode FSM, busy/ready handshake, read-data return.
// Valid/req/error pulses come 1 cycle after the internal word event; ready drops in that same cycle.
module it8951_spi_responder #(
  parameter int BUSY_CYCLES = 16
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        spi_clk,
  input  logic        spi_cs,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        it8951_ready,
  input  logic        hold_busy,
  output logic        cmd_valid,
  output logic [15:0] cmd_code,
  output logic        wdata_valid,
  output logic [15:0] wdata,
  output logic        rdata_req,
  input  logic [15:0] rdata,
  output logic        frame_error
);
  import it8951_pkg::*;

  localparam int BW = $clog2(BUSY_CYCLES + 1);

  state_t        state_q, state_d;
  logic [BW-1:0] busy_cnt, busy_next;
  logic          ready_q;
  logic          rdata_req_d;
  logic          cmd_set, wr_set, req_set, err_set, load_now;
  logic          word_done, cs_rise, cs_fall, partial, tx_msb;
  logic [15:0]   rx_word;

  spi_slave_shifter u_shifter (
    .clk_in      (clk_in),
    .rst         (rst),
    .spi_clk     (spi_clk),
    .spi_cs      (spi_cs),
    .spi_mosi    (spi_mosi),
    .tx_load     (load_now | rdata_req_d),
    .tx_data     (rdata),
    .tx_shift_en (state_q == ST_RDATA),
    .word_done   (word_done),
    .rx_word     (rx_word),
    .cs_rise     (cs_rise),
    .cs_fall     (cs_fall),
    .partial     (partial),
    .tx_msb      (tx_msb)
  );

  always_comb begin
    state_d  = state_q;
    cmd_set  = 1'b0;
    wr_set   = 1'b0;
    req_set  = 1'b0;
    err_set  = 1'b0;
    load_now = 1'b0;
    case (state_q)
      ST_IDLE:     if (cs_fall) state_d = ST_PREAMBLE;
      ST_PREAMBLE: if (word_done) begin
        case (rx_word)
          PREAMBLE_CMD:   state_d = ST_CMD;
          PREAMBLE_WRITE: state_d = ST_WDATA;
          PREAMBLE_READ: begin
            state_d = ST_RDUMMY;
            req_set = 1'b1;
          end
          default: begin
            state_d = ST_DISCARD;
            err_set = 1'b1;
          end
        endcase
      end
      ST_CMD:      cmd_set = word_done;
      ST_WDATA:    wr_set  = word_done;
      ST_RDUMMY:   if (word_done) begin
        load_now = 1'b1;
        state_d  = ST_RDATA;
      end
      // each request supplies the word shifted out during the next word; it is latched once valid
      ST_RDATA:    req_set = word_done;
      default:     ;
    endcase
    if (cs_rise) begin
      state_d = ST_IDLE;
      if (partial) err_set = 1'b1;
    end
  end

  always_comb begin
    if (word_done)
      busy_next = BW'(BUSY_CYCLES);
    else if (busy_cnt != '0)
      busy_next = busy_cnt - BW'(1);
    else
      busy_next = busy_cnt;
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      busy_cnt    <= '0;
      ready_q     <= 1'b0;
      cmd_valid   <= 1'b0;
      cmd_code    <= '0;
      wdata_valid <= 1'b0;
      wdata       <= '0;
      rdata_req   <= 1'b0;
      rdata_req_d <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_cnt    <= busy_next;
      ready_q     <= (busy_next == '0);
      cmd_valid   <= cmd_set;
      wdata_valid <= wr_set;
      rdata_req   <= req_set;
      rdata_req_d <= rdata_req;
      frame_error <= err_set;
      if (cmd_set) cmd_code <= rx_word;
      if (wr_set)  wdata    <= rx_word;
    end
  end

  assign it8951_ready = ready_q & ~hold_busy;
  assign spi_miso     = (state_q == ST_RDATA) & tx_msb;

endmodule
